// File: rtl/load_align_pkg.sv
// Shared definitions for the load alignment unit: FSM states, access-size
// encodings and a size-to-byte-count helper.
package load_align_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE0,
    WAIT0,
    ISSUE1,
    WAIT1,
    OUT
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    logic [3:0] bytes;
    case (size)
      SZ_B:    bytes = 4'd1;
      SZ_H:    bytes = 4'd2;
      SZ_W:    bytes = 4'd4;
      default: bytes = 4'd8;
    endcase
    return bytes;
  endfunction

endpackage

// File: rtl/lane_extract.sv
// Combinational byte-lane extractor: selects the addressed bytes out of a
// two-word window and sign- or zero-extends them to a full word.
module lane_extract
  import load_align_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W-1:0]          i_data,
  input  logic [$clog2(DATA_W/8)-1:0]  i_off,
  input  logic [1:0]                   i_size,
  input  logic                         i_sign,
  output logic [DATA_W-1:0]            o_data
);

  logic [DATA_W-1:0] w_win;

  // Full-width (and wider) accesses never get filled, so sign is ignored there.
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] win,
                                               input logic [1:0]        size,
                                               input logic              sign);
    logic [DATA_W-1:0] res;
    logic              fill;
    int                nbits;
    nbits = int'({size_bytes(size), 3'b000});
    fill  = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i == nbits - 1) fill = sign & win[i];
    end
    res = win;
    for (int i = 0; i < DATA_W; i++) begin
      if (i >= nbits) res[i] = fill;
    end
    return res;
  endfunction

  assign w_win  = DATA_W'(i_data >> {i_off, 3'b000});
  assign o_data = extend(w_win, i_size, i_sign);

endmodule

// File: rtl/load_align_unit.sv
// Load-data alignment unit: issues one or two aligned word reads for a byte
// address and returns the extracted, extended load result over valid/ready.
module load_align_unit
  import load_align_pkg::*;
#(
  parameter int DATA_W           = 32,
  parameter int ADDR_W           = 32,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_sign,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);

  localparam int N     = DATA_W / 8;
  localparam int OFF_W = $clog2(N);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_sign;
  logic [DATA_W-1:0] r_lo;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_err;

  logic [OFF_W-1:0]  w_req_off;
  logic [3:0]        w_req_bytes;
  logic              w_req_err;
  logic [OFF_W-1:0]  w_off;
  logic [3:0]        w_bytes;
  logic              w_spans;
  logic [ADDR_W-1:0] w_base;
  logic [DATA_W-1:0] w_ext_lo;
  logic [DATA_W-1:0] w_ext_hi;
  logic [DATA_W-1:0] w_ext;

  assign w_req_off   = req_addr[OFF_W-1:0];
  assign w_req_bytes = size_bytes(req_size);
  assign w_req_err   = ((DATA_W < 64) && (req_size == SZ_D)) ||
                       ((ALLOW_MISALIGNED == 0) &&
                        ((4'(w_req_off) & (w_req_bytes - 4'd1)) != 4'd0));

  assign w_off   = r_addr[OFF_W-1:0];
  assign w_bytes = size_bytes(r_size);
  assign w_spans = (5'(w_off) + 5'(w_bytes)) > 5'(N);
  assign w_base  = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  // The result is registered on the same edge that captures the last read
  // word, so the extractor looks at mem_rdata directly in the wait states.
  assign w_ext_lo = (r_state == WAIT0) ? mem_rdata : r_lo;
  assign w_ext_hi = (r_state == WAIT1) ? mem_rdata : r_hi;

  lane_extract #(
    .DATA_W(DATA_W)
  ) u_lane_extract (
    .i_data (({w_ext_hi, w_ext_lo})),
    .i_off  (w_off),
    .i_size (r_size),
    .i_sign (r_sign),
    .o_data (w_ext)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    mem_addr      = '0;
    rsp_valid     = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = w_req_err ? OUT : ISSUE0;
      end
      ISSUE0: begin
        mem_req_valid = 1'b1;
        mem_addr      = w_base;
        if (mem_req_ready) w_state_nxt = WAIT0;
      end
      WAIT0: begin
        if (mem_rsp_valid) w_state_nxt = w_spans ? ISSUE1 : OUT;
      end
      ISSUE1: begin
        mem_req_valid = 1'b1;
        mem_addr      = w_base + ADDR_W'(N);
        if (mem_req_ready) w_state_nxt = WAIT1;
      end
      WAIT1: begin
        if (mem_rsp_valid) w_state_nxt = OUT;
      end
      OUT: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr     <= '0;
      r_size     <= '0;
      r_sign     <= 1'b0;
      r_lo       <= '0;
      r_hi       <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_addr     <= req_addr;
            r_size     <= req_size;
            r_sign     <= req_sign;
            r_lo       <= '0;
            r_hi       <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= w_req_err;
          end
        end
        WAIT0: begin
          if (mem_rsp_valid) begin
            r_lo <= mem_rdata;
            if (!w_spans) r_rsp_data <= w_ext;
          end
        end
        WAIT1: begin
          if (mem_rsp_valid) begin
            r_hi       <= mem_rdata;
            r_rsp_data <= w_ext;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_data = r_rsp_data;
  assign rsp_err  = r_rsp_err;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: one instance with misaligned splitting,
// one with misaligned trapping, driven by a small word-memory responder.
module tb_load_align_unit;

  logic        clk;
  logic        reset;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_sign;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  logic        req_valid2, req_ready2;
  logic        mem_req_valid2, mem_req_ready2;
  logic [31:0] mem_addr2;
  logic        mem_rsp_valid2;
  logic [31:0] mem_rdata2;
  logic        rsp_valid2, rsp_ready2;
  logic [31:0] rsp_data2;
  logic        rsp_err2;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          rd_cnt  = 0;
  int          n_deliv = 0;
  int          rsp_delay = 0;
  logic [31:0] rd_log [0:63];
  logic        mem_req_seen2 = 1'b0;

  load_align_unit #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGNED(1)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_sign(req_sign),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  load_align_unit #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGNED(0)) u_dut_trap (
    .clk(clk), .reset(reset),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_addr(req_addr),
    .req_size(req_size), .req_sign(req_sign),
    .mem_req_valid(mem_req_valid2), .mem_req_ready(mem_req_ready2), .mem_addr(mem_addr2),
    .mem_rsp_valid(mem_rsp_valid2), .mem_rdata(mem_rdata2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_data(rsp_data2), .rsp_err(rsp_err2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'hF3E2_D1C0;
      32'h0000_0104: return 32'h8765_4321;
      32'hFFFF_FFFC: return 32'hAABB_CCDD;
      32'h0000_0000: return 32'h1122_3344;
      default:       return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Memory responder: answers an accepted read after 1 + rsp_delay cycles.
  initial begin : mem_model
    logic [31:0] a;
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;
    forever begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) begin
        a = mem_addr;
        if (rd_cnt < 64) rd_log[rd_cnt] = a;
        rd_cnt++;
        @(posedge clk); #1;
        repeat (rsp_delay) begin @(posedge clk); #1; end
        mem_rsp_valid = 1'b1;
        mem_rdata     = mem_word(a);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
      end
    end
  end

  initial begin : monitors
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) n_deliv++;
      if (mem_req_valid2) mem_req_seen2 = 1'b1;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Issue one load on the splitting instance and check result, latency and reads.
  task automatic run_load(input string tag, input logic [31:0] a, input logic [1:0] s,
                          input logic sg, input logic [31:0] exp_data, input logic exp_err,
                          input int exp_lat, input int exp_rds,
                          input logic [31:0] exp_a0, input logic [31:0] exp_a1);
    int rd0;
    int lat;
    rd0 = rd_cnt;
    lat = 0;
    req_addr  = a;
    req_size  = s;
    req_sign  = sg;
    req_valid = 1'b1;
    @(negedge clk);
    check_eq({tag, "/req_ready"}, 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (rsp_valid) lat = k;
    end
    check_eq({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "/data"}, 64'(rsp_data), 64'(exp_data));
    check_eq({tag, "/err"}, 64'(rsp_err), 64'(exp_err));
    @(posedge clk); #1;
    check_eq({tag, "/reads"}, 64'(rd_cnt - rd0), 64'(exp_rds));
    if (exp_rds > 0) check_eq({tag, "/addr0"}, 64'(rd_log[rd0]), 64'(exp_a0));
    if (exp_rds > 1) check_eq({tag, "/addr1"}, 64'(rd_log[rd0+1]), 64'(exp_a1));
  endtask

  initial begin : stim
    int d0;
    int r0;
    int lat;
    reset          = 1'b1;
    req_valid      = 1'b0;
    req_addr       = '0;
    req_size       = '0;
    req_sign       = 1'b0;
    mem_req_ready  = 1'b1;
    rsp_ready      = 1'b1;
    req_valid2     = 1'b0;
    mem_req_ready2 = 1'b1;
    mem_rsp_valid2 = 1'b0;
    mem_rdata2     = '0;
    rsp_ready2     = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check_eq("reset/req_ready", 64'(req_ready), 64'd1);
    check_eq("reset/mem_req_valid", 64'(mem_req_valid), 64'd0);
    check_eq("reset/mem_addr", 64'(mem_addr), 64'd0);
    check_eq("reset/rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("reset/rsp_data", 64'(rsp_data), 64'd0);
    check_eq("reset/rsp_err", 64'(rsp_err), 64'd0);
    @(posedge clk); #1;

    run_load("byte_s",    32'h103, 2'd0, 1'b1, 32'hFFFF_FFF3, 1'b0, 3, 1, 32'h100, 32'h0);
    run_load("byte_u",    32'h103, 2'd0, 1'b0, 32'h0000_00F3, 1'b0, 3, 1, 32'h100, 32'h0);
    run_load("half_s",    32'h102, 2'd1, 1'b1, 32'hFFFF_F3E2, 1'b0, 3, 1, 32'h100, 32'h0);
    run_load("word_mis",  32'h102, 2'd2, 1'b1, 32'h4321_F3E2, 1'b0, 5, 2, 32'h100, 32'h104);
    run_load("half_span", 32'h103, 2'd1, 1'b1, 32'h0000_21F3, 1'b0, 5, 2, 32'h100, 32'h104);
    run_load("dword_ill", 32'h100, 2'd3, 1'b1, 32'h0000_0000, 1'b1, 1, 0, 32'h0,   32'h0);
    run_load("word_al",   32'h104, 2'd2, 1'b1, 32'h8765_4321, 1'b0, 3, 1, 32'h104, 32'h0);
    run_load("half_hi",   32'h106, 2'd1, 1'b1, 32'hFFFF_8765, 1'b0, 3, 1, 32'h104, 32'h0);
    run_load("half_odd",  32'h101, 2'd1, 1'b0, 32'h0000_E2D1, 1'b0, 3, 1, 32'h100, 32'h0);
    run_load("wrap",      32'hFFFF_FFFE, 2'd2, 1'b0, 32'h3344_AABB, 1'b0, 5, 2,
             32'hFFFF_FFFC, 32'h0000_0000);

    // Backpressure on both the memory side and the response side.
    d0 = n_deliv;
    r0 = rd_cnt;
    mem_req_ready = 1'b0;
    rsp_ready     = 1'b0;
    req_addr  = 32'h100;
    req_size  = 2'd1;
    req_sign  = 1'b0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("bp/mem_req_valid", 64'(mem_req_valid), 64'd1);
      check_eq("bp/mem_addr", 64'(mem_addr), 64'h100);
    end
    @(posedge clk); #1;
    mem_req_ready = 1'b1;
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (rsp_valid) lat = k;
    end
    check_eq("bp/latency", 64'(lat), 64'd3);
    check_eq("bp/data", 64'(rsp_data), 64'h0000_D1C0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("bp/rsp_valid_hold", 64'(rsp_valid), 64'd1);
      check_eq("bp/rsp_data_hold", 64'(rsp_data), 64'h0000_D1C0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("bp/rsp_valid_drop", 64'(rsp_valid), 64'd0);
    check_eq("bp/delivered", 64'(n_deliv - d0), 64'd1);
    check_eq("bp/reads", 64'(rd_cnt - r0), 64'd1);
    @(posedge clk); #1;

    // Reset while waiting for read data; the late response must be dropped.
    rsp_delay = 1;
    req_addr  = 32'h100;
    req_size  = 2'd2;
    req_sign  = 1'b0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    d0 = n_deliv;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("rst/rsp_valid", 64'(rsp_valid), 64'd0);
      check_eq("rst/req_ready", 64'(req_ready), 64'd1);
      check_eq("rst/mem_req_valid", 64'(mem_req_valid), 64'd0);
      check_eq("rst/mem_addr", 64'(mem_addr), 64'd0);
      check_eq("rst/rsp_data", 64'(rsp_data), 64'd0);
      check_eq("rst/rsp_err", 64'(rsp_err), 64'd0);
    end
    check_eq("rst/delivered", 64'(n_deliv - d0), 64'd0);
    rsp_delay = 0;
    @(posedge clk); #1;
    run_load("after_rst", 32'h104, 2'd0, 1'b1, 32'h0000_0021, 1'b0, 3, 1, 32'h104, 32'h0);

    // Trapping instance: misaligned accesses are flagged without any read.
    req_addr   = 32'h102;
    req_size   = 2'd2;
    req_sign   = 1'b0;
    req_valid2 = 1'b1;
    @(negedge clk);
    check_eq("trap_w/req_ready", 64'(req_ready2), 64'd1);
    @(posedge clk); #1;
    req_valid2 = 1'b0;
    @(negedge clk);
    check_eq("trap_w/rsp_valid", 64'(rsp_valid2), 64'd1);
    check_eq("trap_w/rsp_err", 64'(rsp_err2), 64'd1);
    check_eq("trap_w/rsp_data", 64'(rsp_data2), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("trap_w/rsp_valid_drop", 64'(rsp_valid2), 64'd0);
    @(posedge clk); #1;
    req_addr   = 32'h101;
    req_size   = 2'd1;
    req_valid2 = 1'b1;
    @(posedge clk); #1;
    req_valid2 = 1'b0;
    @(negedge clk);
    check_eq("trap_h/rsp_valid", 64'(rsp_valid2), 64'd1);
    check_eq("trap_h/rsp_err", 64'(rsp_err2), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("trap/mem_req_never", 64'(mem_req_seen2), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
